// File: rtl/io_sw_debounce_pkg.sv
// Shared I/O constants for the switch block: default geometry, register map and channel states.
package io_sw_debounce_pkg;

   localparam int IO_SW_NUM_DEF      = 32;
   localparam int IO_SW_SYNC_DEF     = 2;
   localparam int IO_SW_DEBOUNCE_DEF = 4;

   localparam int          IO_ADDR_W        = 16;
   localparam int          IO_DATA_W        = 32;
   localparam logic [15:0] IO_SW_ADDR       = 16'h0010;
   localparam logic [15:0] IO_SW_FLAG_ADDR  = 16'h0014;
   localparam logic [15:0] IO_SW_IRQEN_ADDR = 16'h0018;

   // Derived per channel: STABLE when the synchronised level matches the accepted one.
   typedef enum logic {
      STABLE   = 1'b0,
      COUNTING = 1'b1
   } sw_state_e;

endpackage

// File: rtl/io_sw_debounce_ch.sv
// One switch channel: synchroniser, debounce counter, accepted level, edge pulses and sticky flag.
module sw_debounce_ch
   import io_sw_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = IO_SW_SYNC_DEF,
   parameter int DEBOUNCE_CYCLES = IO_SW_DEBOUNCE_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sw_i,
   input  logic clr_i,
   output logic sw_o,
   output logic rise_o,
   output logic fall_o,
   output logic flag_o
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   sw_state_e              state_s;
   logic                   accept_s;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   sw_q, sw_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   flag_q, flag_d;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Metastability chain; only the last stage feeds the debounce logic.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
      end
   end

   // A mismatch must persist DEBOUNCE_CYCLES cycles; any return to the old level restarts the count.
   always_comb begin
      state_s  = (sync_s != sw_q) ? COUNTING : STABLE;
      accept_s = 1'b0;
      cnt_d    = cnt_q;
      sw_d     = sw_q;
      case (state_s)
         STABLE: begin
            cnt_d = {CNT_W{1'b0}};
         end
         COUNTING: begin
            if (cnt_q == CNT_LAST) begin
               accept_s = 1'b1;
               sw_d     = sync_s;
               cnt_d    = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d = {CNT_W{1'b0}};
         end
      endcase
      rise_d = accept_s & sync_s;
      fall_d = accept_s & ~sync_s;
      // A new edge wins over a simultaneous clear.
      flag_d = accept_s | (flag_q & ~clr_i);
   end

   // Channel state and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= {CNT_W{1'b0}};
         sw_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sw_q   <= sw_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         flag_q <= flag_d;
      end
   end

   assign sw_o   = sw_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   assign flag_o = flag_q;

endmodule

// File: rtl/io_sw_debounce.sv
// Switch input block: NUM_SW independent debounced channels plus the shared interrupt line.
module io_sw_debounce
   import io_sw_debounce_pkg::*;
#(
   parameter int NUM_SW          = IO_SW_NUM_DEF,
   parameter int SYNC_STAGES     = IO_SW_SYNC_DEF,
   parameter int DEBOUNCE_CYCLES = IO_SW_DEBOUNCE_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NUM_SW-1:0] io_sw_i,
   input  logic [NUM_SW-1:0] clr_i,
   input  logic [NUM_SW-1:0] irq_en_i,
   output logic [NUM_SW-1:0] sw_o,
   output logic [NUM_SW-1:0] rise_o,
   output logic [NUM_SW-1:0] fall_o,
   output logic [NUM_SW-1:0] edge_flag_o,
   output logic              irq_o
);

   for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
      sw_debounce_ch #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .sw_i   (io_sw_i[i]),
         .clr_i  (clr_i[i]),
         .sw_o   (sw_o[i]),
         .rise_o (rise_o[i]),
         .fall_o (fall_o[i]),
         .flag_o (edge_flag_o[i])
      );
   end

   // Combinational so a clear drops the interrupt in the same cycle the flag clears.
   assign irq_o = |(edge_flag_o & irq_en_i);

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce: default instance plus a 1-channel, 3-stage, no-debounce instance.
module tb_io_sw_debounce;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] io_sw, clr, irq_en;
   logic [31:0] sw, rise, fall, flag;
   logic        irq;

   logic        rst2_n;
   logic [0:0]  io2, clr2, en2, sw2, rise2, fall2, flag2;
   logic        irq2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_sw_debounce u_dut (
      .clk_i(clk), .rst_ni(rst_n), .io_sw_i(io_sw), .clr_i(clr), .irq_en_i(irq_en),
      .sw_o(sw), .rise_o(rise), .fall_o(fall), .edge_flag_o(flag), .irq_o(irq)
   );

   io_sw_debounce #(.NUM_SW(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u_dut2 (
      .clk_i(clk), .rst_ni(rst2_n), .io_sw_i(io2), .clr_i(clr2), .irq_en_i(en2),
      .sw_o(sw2), .rise_o(rise2), .fall_o(fall2), .edge_flag_o(flag2), .irq_o(irq2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0;
      io_sw = 32'h2; clr = 32'h0; irq_en = 32'h0;
      io2 = 1'b1; clr2 = 1'b0; en2 = 1'b1;
      tick(3);
      chk("rst_sw", sw, 32'h0);
      chk("rst_flag", flag, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);

      // Held level through reset appears exactly 6 edges after release.
      rst_n = 1'b1;
      tick(5);
      chk("lat5_sw", sw, 32'h0);
      tick(1);
      chk("lat6_sw", sw, 32'h2);
      chk("lat6_rise", rise, 32'h2);
      chk("lat6_flag", flag, 32'h2);
      tick(1);
      chk("lat7_rise", rise, 32'h0);

      // Parallel rise and fall.
      io_sw = 32'h5;
      tick(5);
      chk("mix5_sw", sw, 32'h2);
      tick(1);
      chk("mix6_sw", sw, 32'h5);
      chk("mix6_rise", rise, 32'h5);
      chk("mix6_fall", fall, 32'h2);
      chk("mix6_flag", flag, 32'h7);
      tick(1);
      chk("mix7_rise", rise, 32'h0);
      chk("mix7_fall", fall, 32'h0);

      // Clear one flag; interrupt follows without delay.
      irq_en = 32'h4;
      #1;
      chk("irq_on", {31'h0, irq}, 32'h1);
      clr = 32'h4;
      tick(1);
      clr = 32'h0;
      chk("clr_flag", flag, 32'h3);
      chk("clr_irq", {31'h0, irq}, 32'h0);

      // Clear coinciding with a new edge on bit 2: set wins.
      io_sw = 32'h1;
      tick(5);
      clr = 32'h4;
      tick(1);
      clr = 32'h0;
      chk("setwin_sw", sw, 32'h1);
      chk("setwin_fall", fall, 32'h4);
      chk("setwin_flag", flag, 32'h7);
      chk("setwin_irq", {31'h0, irq}, 32'h1);

      // Three-cycle glitch on bit 3 is rejected.
      io_sw = 32'h9;
      tick(3);
      io_sw = 32'h1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("glitch_sw", sw, 32'h1);
         chk("glitch_rise", rise, 32'h0);
      end
      chk("glitch_flag", flag, 32'h7);

      // Four-cycle pulse is accepted, then its return is accepted too.
      io_sw = 32'h9;
      tick(4);
      io_sw = 32'h1;
      tick(2);
      chk("pulse_sw", sw, 32'h9);
      chk("pulse_rise", rise, 32'h8);
      tick(3);
      chk("pulse9_sw", sw, 32'h9);
      tick(1);
      chk("pulse10_sw", sw, 32'h1);
      chk("pulse10_fall", fall, 32'h8);
      chk("pulse10_flag", flag, 32'hF);

      // Reset in the middle of a count.
      clr = 32'hF;
      tick(1);
      clr = 32'h0;
      chk("clrall_flag", flag, 32'h0);
      io_sw = 32'h6;
      tick(6);
      chk("pre_sw", sw, 32'h6);
      io_sw = 32'h7;
      tick(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sw", sw, 32'h0);
      chk("mid_rst_pulse", rise | fall, 32'h0);
      chk("mid_rst_flag", flag, 32'h0);
      tick(1);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("post_rst_pulse", rise | fall, 32'h0);
         chk("post_rst_sw", sw, 32'h0);
      end
      tick(1);
      chk("post_rst6_sw", sw, 32'h7);
      chk("post_rst6_rise", rise, 32'h7);
      chk("post_rst6_fall", fall, 32'h0);

      // Scaled instance: latency 4 edges.
      rst2_n = 1'b1;
      tick(3);
      chk("s_lat3_sw", {31'h0, sw2}, 32'h0);
      tick(1);
      chk("s_lat4_sw", {31'h0, sw2}, 32'h1);
      chk("s_lat4_rise", {31'h0, rise2}, 32'h1);
      chk("s_lat4_irq", {31'h0, irq2}, 32'h1);
      tick(1);
      chk("s_lat5_rise", {31'h0, rise2}, 32'h0);
      clr2 = 1'b1;
      tick(1);
      clr2 = 1'b0;
      chk("s_clr_flag", {31'h0, flag2}, 32'h0);
      chk("s_clr_irq", {31'h0, irq2}, 32'h0);
      io2 = 1'b0;
      tick(3);
      chk("s_fall3_sw", {31'h0, sw2}, 32'h1);
      tick(1);
      chk("s_fall4_sw", {31'h0, sw2}, 32'h0);
      chk("s_fall4_fall", {31'h0, fall2}, 32'h1);
      chk("s_fall4_flag", {31'h0, flag2}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
